// File: rtl/axi_multi_id_serializer.sv
// AXI4+ATOP ID serializer: folds upstream IDs onto 2**MstIdWidth downstream IDs,
// serializing per downstream ID and restoring upstream IDs on R/B from per-ID FIFOs.
package axi_mis_pkg;
  typedef struct packed {
    logic [0:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } aw_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_t;
  typedef struct packed {
    logic [0:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_t;
  typedef struct packed {
    logic [0:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ar_t;
  typedef struct packed {
    logic [0:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_t;
  typedef struct packed {
    aw_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ar_t  ar;
    logic ar_valid;
    logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    logic b_valid;
    b_t   b;
    logic r_valid;
    r_t   r;
  } resp_t;
endpackage

module axi_mis_id_fifo #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             last,
  output logic [Width-1:0] head
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr, rptr;
  logic [CntW-1:0]  cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == CntW'(Depth));
  assign empty   = (cnt == '0);
  assign last    = (cnt == CntW'(1));
  assign head    = mem[rptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= (wptr == PtrW'(Depth - 1)) ? '0 : wptr + PtrW'(1);
      end
      if (do_pop) rptr <= (rptr == PtrW'(Depth - 1)) ? '0 : rptr + PtrW'(1);
      cnt <= cnt + CntW'(do_push) - CntW'(do_pop);
    end
  end
endmodule

module axi_multi_id_serializer #(
  parameter int unsigned MaxReadTxns  = 1,
  parameter int unsigned MaxWriteTxns = 1,
  parameter int unsigned SlvIdWidth   = 1,
  parameter int unsigned MstIdWidth   = 1,
  parameter type slv_req_t  = axi_mis_pkg::req_t,
  parameter type slv_resp_t = axi_mis_pkg::resp_t,
  parameter type mst_req_t  = axi_mis_pkg::req_t,
  parameter type mst_resp_t = axi_mis_pkg::resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  slv_req_t  slv_req_i,
  output slv_resp_t slv_resp_o,
  output mst_req_t  mst_req_o,
  input  mst_resp_t mst_resp_i
);
  localparam int unsigned NumIds    = 2 ** MstIdWidth;
  localparam logic [1:0]  AtopNone  = 2'b00;
  localparam int unsigned AtopRResp = 5;

  typedef enum logic [1:0] {Idle, Drain, Execute} state_e;
  state_e state;

  logic [NumIds-1:0]     rd_push, rd_pop, rd_full, rd_empty, rd_last;
  logic [NumIds-1:0]     wr_push, wr_pop, wr_full, wr_empty, wr_last;
  logic [SlvIdWidth-1:0] rd_head [NumIds];
  logic [SlvIdWidth-1:0] wr_head [NumIds];
  logic [SlvIdWidth-1:0] rd_push_id;
  logic [MstIdWidth-1:0] ar_mid, aw_mid, r_mid, b_mid;
  logic aw_atop, all_empty, drained_now, adm_open;
  logic r_vld, r_rdy, b_vld, b_rdy;
  logic ar_vld, ar_rdy, aw_vld, aw_rdy, ar_hs, aw_hs;

  assign ar_mid  = slv_req_i.ar.id[MstIdWidth-1:0];
  assign aw_mid  = slv_req_i.aw.id[MstIdWidth-1:0];
  assign r_mid   = mst_resp_i.r.id;
  assign b_mid   = mst_resp_i.b.id;
  assign aw_atop = (slv_req_i.aw.atop[5:4] != AtopNone);

  for (genvar i = 0; i < NumIds; i++) begin : g_fifo
    axi_mis_id_fifo #(.Depth(MaxReadTxns), .Width(SlvIdWidth)) i_rd (
      .clk_i(clk_i), .rst_i(rst_i), .push(rd_push[i]), .push_data(rd_push_id),
      .pop(rd_pop[i]), .full(rd_full[i]), .empty(rd_empty[i]), .last(rd_last[i]),
      .head(rd_head[i])
    );
    axi_mis_id_fifo #(.Depth(MaxWriteTxns), .Width(SlvIdWidth)) i_wr (
      .clk_i(clk_i), .rst_i(rst_i), .push(wr_push[i]), .push_data(slv_req_i.aw.id),
      .pop(wr_pop[i]), .full(wr_full[i]), .empty(wr_empty[i]), .last(wr_last[i]),
      .head(wr_head[i])
    );
  end

  // Responses whose ID FIFO is empty are held off rather than forwarded.
  assign r_vld  = ~rst_i & mst_resp_i.r_valid & ~rd_empty[r_mid];
  assign r_rdy  = ~rst_i & slv_req_i.r_ready & ~rd_empty[r_mid];
  assign b_vld  = ~rst_i & mst_resp_i.b_valid & ~wr_empty[b_mid];
  assign b_rdy  = ~rst_i & slv_req_i.b_ready & ~wr_empty[b_mid];
  assign rd_pop = (r_vld & r_rdy & mst_resp_i.r.last) ? (NumIds'(1) << r_mid) : '0;
  assign wr_pop = (b_vld & b_rdy) ? (NumIds'(1) << b_mid) : '0;

  assign all_empty   = &{rd_empty, wr_empty};
  assign drained_now = &{rd_empty | (rd_last & rd_pop), wr_empty | (wr_last & wr_pop)};

  always_comb begin
    ar_vld   = 1'b0;
    ar_rdy   = 1'b0;
    aw_vld   = 1'b0;
    aw_rdy   = 1'b0;
    adm_open = (state == Idle) || ((state == Execute) && drained_now);
    if (!rst_i) begin
      if (adm_open) begin
        ar_vld = slv_req_i.ar_valid & ~rd_full[ar_mid];
        ar_rdy = mst_resp_i.ar_ready & ~rd_full[ar_mid];
        if (!aw_atop) begin
          aw_vld = slv_req_i.aw_valid & ~wr_full[aw_mid];
          aw_rdy = mst_resp_i.aw_ready & ~wr_full[aw_mid];
        end
      end else if (state == Drain) begin
        aw_vld = slv_req_i.aw_valid & all_empty;
        aw_rdy = mst_resp_i.aw_ready & all_empty;
      end
    end
  end

  assign ar_hs = ar_vld & ar_rdy;
  assign aw_hs = aw_vld & aw_rdy;
  // An ATOP with a read response also owns a slot in the read FIFO of its ID.
  assign rd_push_id = (state == Drain) ? slv_req_i.aw.id : slv_req_i.ar.id;
  assign rd_push = ar_hs ? (NumIds'(1) << ar_mid) :
                   (aw_hs && (state == Drain) && slv_req_i.aw.atop[AtopRResp]) ?
                   (NumIds'(1) << aw_mid) : '0;
  assign wr_push = aw_hs ? (NumIds'(1) << aw_mid) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= Idle;
    end else begin
      unique case (state)
        Idle:    if (slv_req_i.aw_valid && aw_atop && (!slv_req_i.ar_valid || ar_hs)) state <= Drain;
        Drain:   if (aw_hs) state <= Execute;
        Execute: if (drained_now) state <= Idle;
        default: state <= Idle;
      endcase
    end
  end

  always_comb begin
    mst_req_o  = '0;
    slv_resp_o = '0;
    mst_req_o.aw.id     = aw_mid;
    mst_req_o.aw.addr   = slv_req_i.aw.addr;
    mst_req_o.aw.len    = slv_req_i.aw.len;
    mst_req_o.aw.size   = slv_req_i.aw.size;
    mst_req_o.aw.burst  = slv_req_i.aw.burst;
    mst_req_o.aw.lock   = slv_req_i.aw.lock;
    mst_req_o.aw.cache  = slv_req_i.aw.cache;
    mst_req_o.aw.prot   = slv_req_i.aw.prot;
    mst_req_o.aw.qos    = slv_req_i.aw.qos;
    mst_req_o.aw.region = slv_req_i.aw.region;
    mst_req_o.aw.atop   = slv_req_i.aw.atop;
    mst_req_o.aw.user   = slv_req_i.aw.user;
    mst_req_o.aw_valid  = aw_vld;
    mst_req_o.w.data    = slv_req_i.w.data;
    mst_req_o.w.strb    = slv_req_i.w.strb;
    mst_req_o.w.last    = slv_req_i.w.last;
    mst_req_o.w.user    = slv_req_i.w.user;
    mst_req_o.w_valid   = ~rst_i & slv_req_i.w_valid;
    mst_req_o.b_ready   = b_rdy;
    mst_req_o.ar.id     = ar_mid;
    mst_req_o.ar.addr   = slv_req_i.ar.addr;
    mst_req_o.ar.len    = slv_req_i.ar.len;
    mst_req_o.ar.size   = slv_req_i.ar.size;
    mst_req_o.ar.burst  = slv_req_i.ar.burst;
    mst_req_o.ar.lock   = slv_req_i.ar.lock;
    mst_req_o.ar.cache  = slv_req_i.ar.cache;
    mst_req_o.ar.prot   = slv_req_i.ar.prot;
    mst_req_o.ar.qos    = slv_req_i.ar.qos;
    mst_req_o.ar.region = slv_req_i.ar.region;
    mst_req_o.ar.user   = slv_req_i.ar.user;
    mst_req_o.ar_valid  = ar_vld;
    mst_req_o.r_ready   = r_rdy;
    slv_resp_o.aw_ready = aw_rdy;
    slv_resp_o.ar_ready = ar_rdy;
    slv_resp_o.w_ready  = ~rst_i & mst_resp_i.w_ready;
    slv_resp_o.b.id     = wr_head[b_mid];
    slv_resp_o.b.resp   = mst_resp_i.b.resp;
    slv_resp_o.b.user   = mst_resp_i.b.user;
    slv_resp_o.b_valid  = b_vld;
    slv_resp_o.r.id     = rd_head[r_mid];
    slv_resp_o.r.data   = mst_resp_i.r.data;
    slv_resp_o.r.resp   = mst_resp_i.r.resp;
    slv_resp_o.r.last   = mst_resp_i.r.last;
    slv_resp_o.r.user   = mst_resp_i.r.user;
    slv_resp_o.r_valid  = r_vld;
  end

  a_r_has_id: assert property (@(posedge clk_i) disable iff (rst_i)
    mst_resp_i.r_valid |-> !rd_empty[r_mid]);
  a_b_has_id: assert property (@(posedge clk_i) disable iff (rst_i)
    mst_resp_i.b_valid |-> !wr_empty[b_mid]);
endmodule

// File: doc/axi_multi_id_serializer.md
# axi_multi_id_serializer

Generalised AXI4+ATOP ID serializer. It folds an arbitrary upstream ID space onto `2**MstIdWidth` downstream IDs and serializes all transactions that share a downstream ID. Original upstream IDs are kept in per-ID read and write FIFOs and restored on R and B. It sits between a many-ID manager and a subordinate or interconnect segment that supports only a few IDs, while still allowing parallelism across distinct downstream IDs.

## Interface
- `MaxReadTxns`, 1: max in-flight reads per downstream ID (read FIFO depth).
- `MaxWriteTxns`, 1: max in-flight writes per downstream ID (write FIFO depth).
- `SlvIdWidth`, 1: upstream ID width, ≥1.
- `MstIdWidth`, 1: downstream ID width, 1..SlvIdWidth; gives `NumIds = 2**MstIdWidth`.
- `slv_req_t`, `slv_resp_t`, logic: AXI4+ATOP request/response structs with SlvIdWidth IDs.
- `mst_req_t`, `mst_resp_t`, logic: AXI4+ATOP request/response structs with MstIdWidth IDs.
- `clk_i` input 1: clock. One clock domain only.
- `rst_i` input 1: reset, synchronous, active-high.
- `slv_req_i` input slv_req_t: upstream request.
- `slv_resp_o` output slv_resp_t: upstream response.
- `mst_req_o` output mst_req_t: downstream request.
- `mst_resp_i` input mst_resp_t: downstream response.

## Operation
- ID map: `mid = slv_id[MstIdWidth-1:0]` for both AW and AR. Mapping is fixed; there is no allocation table.
- Per mid there is one read FIFO (depth MaxReadTxns) and one write FIFO (depth MaxWriteTxns). Each FIFO stores the upstream ID and is not fall-through.
- All payload fields pass through unchanged, except AW/AR IDs, which are replaced by mid, and R/B IDs, which are replaced by the FIFO head of the responding mid. W passes through untouched.
- AR (state Idle): `mst ar_valid = slv ar_valid & ~rd_full[mid]`. `slv ar_ready = mst ar_ready & ~rd_full[mid]`. Push the upstream ID into rd_fifo[mid] on the downstream handshake.
- AW, non-ATOP (state Idle): same gating against wr_full[mid]. Push into wr_fifo[mid] on handshake.
- R: `k = mst r.id`. `slv r_valid = mst r_valid & ~rd_empty[k]`. `mst r_ready = slv r_ready & ~rd_empty[k]`. `slv r.id = rd_head[k]`. Pop rd_fifo[k] on a handshake with `r.last`.
- B: same scheme as R with wr_fifo[k]. Pop on every handshake.
- A response whose FIFO is empty is a protocol error. It is stalled (ready low) and flagged by an assertion.
- FSM states: `Idle`, `Drain`, `Execute`.
  - Idle → Drain: AW pending with `atop[5:4] != ATOP_NONE`, and no AR handshake partially in progress (AR either not valid or completing this cycle).
  - The ATOP AW is never forwarded in Idle.
  - Drain: AW and AR are blocked. Once all 2·NumIds FIFOs are empty, drive the ATOP AW downstream.
    - On handshake, push wr_fifo[mid].
    - If `atop[ATOP_R_RESP]` is set, also push the AW ID into rd_fifo[mid].
    - Go to Execute.
  - Execute → Idle: all FIFOs are empty, or become empty in the current cycle through pops. In that same cycle, AR/AW admission is evaluated as in Idle.
- Parallelism: transactions with different mids proceed concurrently. Transactions with the same mid are ordered, relying on AXI same-ID ordering downstream.

## Timing
- Request and response paths are combinational, with zero added latency.
- An ID pushed in cycle t is visible at the FIFO head in cycle t+1. A response can therefore be forwarded no earlier than one cycle after its request handshake.
- Full FIFO: the push is refused even if a pop occurs on the same FIFO in the same cycle. Ready stays low that cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur.
- Empty FIFO with simultaneous push: the response stays blocked that cycle (no fall-through).
- Reset (`rst_i` high at a clock edge): FIFOs are cleared and the FSM goes to Idle.
  - While `rst_i` is high, every downstream valid (aw, w, ar) and every upstream ready (aw, w, ar) and upstream valid (r, b) is forced to 0.
  - Downstream b_ready and r_ready are forced to 0.
- Reset mid-operation discards all tracked IDs. Downstream responses still outstanding after reset are undefined, and the system resets both sides together.

## Test plan
- Basic remap: SlvIdWidth=4, MstIdWidth=1, AR id 0x5.
  - Required: downstream AR id 1.
  - Required: R with id 1 and last returns upstream id 0x5 no earlier than the next cycle; the FIFO is then empty.
- Per-ID full: MaxReadTxns=2, three ARs with ids 0x2, 0x4, 0x6 (all mid 0), no R responses.
  - Required: the third AR has ar_ready=0.
  - Required: AR id 0x3 (mid 1) is accepted in the same cycle.
- Out-of-order across IDs: AW ids 0x0 and 0x1. Downstream returns B id 1 first, then B id 0.
  - Required: upstream B ids 0x1, then 0x0.
- ATOP drain: one read outstanding, then AW with `atop=ATOP_ATOMICLOAD` and id 0x7.
  - Required: downstream aw_valid stays 0 until the final R.
  - Required: the AW is then issued with id 1, both FIFOs for mid 1 are pushed, and a concurrent AR is blocked until the ATOP's R and B have both popped.
- Full-with-pop: write FIFO of mid 0 full and B popping in the same cycle as a new AW to mid 0.
  - Required: AW is not accepted that cycle and is accepted the next cycle.
- Reset mid-burst: assert `rst_i` with 3 reads in flight.
  - Required: all listed outputs are 0 during reset.
  - Required: after release, FIFOs are empty and the first AR is accepted immediately.
